mod_range_counter: RTL and testbench
====================================

Name: mod_range_counter

Overview:
Parametrised modulo counter for the timekeeping datapath. It counts over a closed range [MIN_VAL, MAX_VAL] in either direction and supports synchronous clear, parallel load with range checking, and a cascade terminal-count output for chaining seconds/minutes/hours stages. The default configuration is the 1..12 hour stage.

Parameters:
WIDTH, 4, counter width in bits
MIN_VAL, 1, lowest count value; reset, clear and wrap target when counting up
MAX_VAL, 12, highest count value; wrap target when counting down; requires MIN_VAL < MAX_VAL <= 2**WIDTH-1 (elaboration-time check)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear to MIN_VAL
enable  in  1  count enable (one step per enabled cycle)
up  in  1  direction: 1 = increment, 0 = decrement
load  in  1  synchronous parallel load strobe
load_val  in  WIDTH  value to load
q  out  WIDTH  current count (registered)
tc  out  1  combinational terminal count: enable & ((up & q==MAX_VAL) | (~up & q==MIN_VAL)) & ~clr & ~load
wrapped  out  1  registered one-cycle pulse, set in the cycle after a wrap occurred
load_err  out  1  registered one-cycle pulse, set in the cycle after an out-of-range load
pm  out  1  half-cycle flag (see Optional Feature); constant 0 when the feature is off

Behaviour:
- Reset (reset_n=0, asynchronous): q=MIN_VAL; wrapped=0; load_err=0; pm=0.
- Per-edge priority: clr > load > enable > hold.
- clr: q<=MIN_VAL; pm<=0; wrapped<=0; load_err<=0.
- load, value in range (MIN_VAL<=load_val<=MAX_VAL): q<=load_val; load_err<=0.
- load, value out of range: q<=MIN_VAL; load_err<=1 for one cycle.
- A load never sets wrapped and never toggles pm.
- enable & up:
  - q==MAX_VAL: q<=MIN_VAL, wrapped<=1.
  - otherwise: q<=q+1.
- enable & ~up:
  - q==MIN_VAL: q<=MAX_VAL, wrapped<=1.
  - otherwise: q<=q-1.
- wrapped and load_err are 0 in every cycle not described above. Both are pulses, not sticky.
- Latency: q updates on the edge where the command is sampled. tc is valid in the same cycle, for synchronous cascading: the next stage's enable = this stage's tc.
- Arithmetic is WIDTH-bit unsigned. q never leaves [MIN_VAL, MAX_VAL] after reset.
- If reset_n asserts mid-count, state is lost immediately. Deassertion is assumed synchronised upstream.

Optional Feature:
Macro PM_FLAG_EN.
- Defined: the pm register toggles when counting up from MAX_VAL-1 to MAX_VAL (11->12), and when counting down from MAX_VAL to MAX_VAL-1 (12->11). Clear and reset force pm=0. Load leaves pm unchanged.
- Undefined: pm is tied to 0 and no flop is inferred.

Decomposition:
- Package counter_pkg: defaults CNT_W_DEF=4, HOUR_MIN=1, HOUR_MAX=12, MIN_MAX=59; typedef for the direction encoding (DIR_DOWN=0, DIR_UP=1).
- One sub-module, mod_range_next: purely combinational. Inputs q, up, enable, load, load_val, clr. Outputs next_q, wrap, range_err, tc.
- The top level holds all registers and the PM_FLAG_EN logic.

Test Plan:
- Reset to 1, enable=1, up=1 for 12 cycles -> q steps 2..12 then 1; tc=1 only while q=12; wrapped=1 in the cycle q shows 1.
- q=1, up=0, enable=1 -> q=12, wrapped pulses; the next decrement gives q=11.
- load=1, load_val=7 with enable=1 in the same cycle -> q=7, load_err=0. Then load_val=13 -> q=1, load_err=1 for exactly one cycle. Then load_val=0 -> q=1, load_err=1.
- clr=1 with load=1 and enable=1 at q=12 -> q=1, wrapped=0, tc=0 in that cycle.
- Cascade of two instances (MIN/MAX 0/59, then 1/12), second enable = first tc: from 59/12, one enabled cycle -> 0/1.
- PM_FLAG_EN defined: count 10->11->12 -> pm toggles 0->1 on the 11->12 edge; count 12->11 -> pm returns to 0. reset_n pulsed low mid-run -> q=1, pm=0 without waiting for a clock edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults and the direction encoding for the timekeeping counter stages.
package counter_pkg;

    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned HOUR_MIN  = 1;
    localparam int unsigned HOUR_MAX  = 12;
    localparam int unsigned MIN_MAX   = 59;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : counter_pkg

// File: rtl/mod_range_counter_if.sv
// Command/status bundle of one modulo counter stage; master drives commands.
interface mod_range_counter_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W_DEF
);

    logic             clr;
    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrapped;
    logic             load_err;
    logic             pm;

    modport master (
        output clr, enable, up, load, load_val,
        input  q, tc, wrapped, load_err, pm
    );

    modport slave (
        input  clr, enable, up, load, load_val,
        output q, tc, wrapped, load_err, pm
    );

endinterface : mod_range_counter_if

// File: rtl/mod_range_next.sv
// Combinational next-count, wrap, load range check and terminal count.
module mod_range_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = CNT_W_DEF,
    parameter int unsigned MIN_VAL = HOUR_MIN,
    parameter int unsigned MAX_VAL = HOUR_MAX
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap,
    output logic             range_err,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MIN_Q  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] SPAN_Q = WIDTH'(MAX_VAL - MIN_VAL);

    dir_e             dir;
    logic [WIDTH-1:0] load_ofs;
    logic             load_ok;
    logic             at_max;
    logic             at_min;

    assign dir    = dir_e'(up);
    assign at_max = (q == MAX_Q);
    assign at_min = (q == MIN_Q);

    // Offset compare: values below MIN wrap to a large offset, so one test covers both bounds
    assign load_ofs = load_val - MIN_Q;
    assign load_ok  = (load_ofs <= SPAN_Q);

    assign tc = enable & ~clr & ~load &
                (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_min));

    // Priority clr > load > enable > hold
    always_comb begin
        next_q    = q;
        wrap      = 1'b0;
        range_err = 1'b0;
        if (clr) begin
            next_q = MIN_Q;
        end else if (load) begin
            if (load_ok) begin
                next_q = load_val;
            end else begin
                next_q    = MIN_Q;
                range_err = 1'b1;
            end
        end else if (enable) begin
            if (dir == DIR_UP) begin
                if (at_max) begin
                    next_q = MIN_Q;
                    wrap   = 1'b1;
                end else begin
                    next_q = q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    next_q = MAX_Q;
                    wrap   = 1'b1;
                end else begin
                    next_q = q - WIDTH'(1);
                end
            end
        end
    end

endmodule : mod_range_next

// File: rtl/mod_range_counter.sv
// Modulo counter over [MIN_VAL, MAX_VAL] with cascade tc; the pm half-cycle
// flag is built only when PM_FLAG_EN is defined.
module mod_range_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = CNT_W_DEF,
    parameter int unsigned MIN_VAL = HOUR_MIN,
    parameter int unsigned MAX_VAL = HOUR_MAX
) (
    input  logic               clk,
    input  logic               reset_n,
    mod_range_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN_VAL);

    if (!((MIN_VAL < MAX_VAL) && (MAX_VAL <= ((2 ** WIDTH) - 1)))) begin : g_bad_range
        $error("mod_range_counter: need MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end

    logic [WIDTH-1:0] q_r;
    logic             wrapped_r;
    logic             load_err_r;
    logic [WIDTH-1:0] next_q;
    logic             wrap;
    logic             range_err;

    mod_range_next #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .q         (q_r),
        .up        (bus.up),
        .enable    (bus.enable),
        .load      (bus.load),
        .load_val  (bus.load_val),
        .clr       (bus.clr),
        .next_q    (next_q),
        .wrap      (wrap),
        .range_err (range_err),
        .tc        (bus.tc)
    );

    // wrap/range_err are already zero outside their cycles, so the flags are pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r        <= MIN_Q;
            wrapped_r  <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            q_r        <= next_q;
            wrapped_r  <= wrap;
            load_err_r <= range_err;
        end
    end

    assign bus.q        = q_r;
    assign bus.wrapped  = wrapped_r;
    assign bus.load_err = load_err_r;

`ifdef PM_FLAG_EN
    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_M1_Q = WIDTH'(MAX_VAL - 1);

    logic pm_r;
    logic pm_tog;

    // Toggle on crossing the MAX-1 <-> MAX boundary in either direction
    assign pm_tog = bus.enable & ~bus.clr & ~bus.load &
                    ((bus.up & (q_r == MAX_M1_Q)) | (~bus.up & (q_r == MAX_Q)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pm_r <= 1'b0;
        end else if (bus.clr) begin
            pm_r <= 1'b0;
        end else if (pm_tog) begin
            pm_r <= ~pm_r;
        end
    end

    assign bus.pm = pm_r;
`else
    assign bus.pm = 1'b0;
`endif

endmodule : mod_range_counter

// File: tb/tb_mod_range_counter.sv
// Directed bench for mod_range_counter (1..12 stage plus a 0..59 -> 1..12 cascade).
module tb_mod_range_counter;

`ifdef PM_FLAG_EN
    localparam bit PM_ON = 1'b1;
`else
    localparam bit PM_ON = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   vecs;
    int   errs;

    mod_range_counter_if #(.WIDTH(4)) bus ();
    mod_range_counter_if #(.WIDTH(6)) sec_bus ();
    mod_range_counter_if #(.WIDTH(4)) hr_bus ();

    assign hr_bus.enable = sec_bus.tc;

    mod_range_counter #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    mod_range_counter #(.WIDTH(6), .MIN_VAL(0), .MAX_VAL(59)) u_sec (
        .clk(clk), .reset_n(reset_n), .bus(sec_bus)
    );
    mod_range_counter #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12)) u_hr (
        .clk(clk), .reset_n(reset_n), .bus(hr_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.clr = 0; bus.enable = 0; bus.up = 0; bus.load = 0; bus.load_val = '0;
        sec_bus.clr = 0; sec_bus.enable = 0; sec_bus.up = 0; sec_bus.load = 0; sec_bus.load_val = '0;
        hr_bus.clr = 0; hr_bus.up = 0; hr_bus.load = 0; hr_bus.load_val = '0;
        #12;
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL reset_q: got %0d expected 1", bus.q); end
        vecs++; if (bus.wrapped !== 1'b0) begin errs++; $display("FAIL reset_wrapped: got %b expected 0", bus.wrapped); end
        vecs++; if (bus.load_err !== 1'b0) begin errs++; $display("FAIL reset_load_err: got %b expected 0", bus.load_err); end
        vecs++; if (bus.pm !== 1'b0) begin errs++; $display("FAIL reset_pm: got %b expected 0", bus.pm); end
        vecs++; if (sec_bus.q !== 6'd0) begin errs++; $display("FAIL reset_sec_q: got %0d expected 0", sec_bus.q); end
        reset_n = 1'b1;
    endtask

    task automatic test_count_up();
        int exp_q[12] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 1};
        bus.enable = 1'b1; bus.up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            vecs++; if (bus.tc !== (i == 11)) begin errs++; $display("FAIL up_tc[%0d]: got %b expected %b", i, bus.tc, (i == 11)); end
            tick();
            vecs++; if (bus.q !== 4'(exp_q[i])) begin errs++; $display("FAIL up_q[%0d]: got %0d expected %0d", i, bus.q, exp_q[i]); end
            vecs++; if (bus.wrapped !== (i == 11)) begin errs++; $display("FAIL up_wrapped[%0d]: got %b expected %b", i, bus.wrapped, (i == 11)); end
        end
    endtask

    task automatic test_count_down();
        bus.enable = 1'b1; bus.up = 1'b0;
        #1;
        vecs++; if (bus.tc !== 1'b1) begin errs++; $display("FAIL dn_tc_at_min: got %b expected 1", bus.tc); end
        tick();
        vecs++; if (bus.q !== 4'd12) begin errs++; $display("FAIL dn_wrap_q: got %0d expected 12", bus.q); end
        vecs++; if (bus.wrapped !== 1'b1) begin errs++; $display("FAIL dn_wrapped: got %b expected 1", bus.wrapped); end
        vecs++; if (bus.tc !== 1'b0) begin errs++; $display("FAIL dn_tc_at_max: got %b expected 0", bus.tc); end
        tick();
        vecs++; if (bus.q !== 4'd11) begin errs++; $display("FAIL dn_step_q: got %0d expected 11", bus.q); end
        vecs++; if (bus.wrapped !== 1'b0) begin errs++; $display("FAIL dn_wrapped_clear: got %b expected 0", bus.wrapped); end
    endtask

    task automatic test_load();
        bus.enable = 1'b1; bus.up = 1'b1; bus.load = 1'b1; bus.load_val = 4'd7;
        #1;
        vecs++; if (bus.tc !== 1'b0) begin errs++; $display("FAIL ld_tc: got %b expected 0", bus.tc); end
        tick();
        vecs++; if (bus.q !== 4'd7) begin errs++; $display("FAIL ld7_q: got %0d expected 7", bus.q); end
        vecs++; if (bus.load_err !== 1'b0) begin errs++; $display("FAIL ld7_err: got %b expected 0", bus.load_err); end
        bus.load_val = 4'd13;
        tick();
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL ld13_q: got %0d expected 1", bus.q); end
        vecs++; if (bus.load_err !== 1'b1) begin errs++; $display("FAIL ld13_err: got %b expected 1", bus.load_err); end
        bus.load = 1'b0; bus.enable = 1'b0;
        tick();
        vecs++; if (bus.load_err !== 1'b0) begin errs++; $display("FAIL ld_err_pulse: got %b expected 0", bus.load_err); end
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL ld_idle_q: got %0d expected 1", bus.q); end
        bus.load = 1'b1; bus.load_val = 4'd0;
        tick();
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL ld0_q: got %0d expected 1", bus.q); end
        vecs++; if (bus.load_err !== 1'b1) begin errs++; $display("FAIL ld0_err: got %b expected 1", bus.load_err); end
        bus.load_val = 4'd12;
        tick();
        vecs++; if (bus.q !== 4'd12) begin errs++; $display("FAIL ld12_q: got %0d expected 12", bus.q); end
        vecs++; if (bus.load_err !== 1'b0) begin errs++; $display("FAIL ld12_err: got %b expected 0", bus.load_err); end
        bus.load = 1'b0;
    endtask

    task automatic test_clr_priority();
        bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 4'd5; bus.enable = 1'b1; bus.up = 1'b1;
        #1;
        vecs++; if (bus.tc !== 1'b0) begin errs++; $display("FAIL clr_tc: got %b expected 0", bus.tc); end
        tick();
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL clr_q: got %0d expected 1", bus.q); end
        vecs++; if (bus.wrapped !== 1'b0) begin errs++; $display("FAIL clr_wrapped: got %b expected 0", bus.wrapped); end
        vecs++; if (bus.load_err !== 1'b0) begin errs++; $display("FAIL clr_load_err: got %b expected 0", bus.load_err); end
        bus.clr = 1'b0; bus.load = 1'b0; bus.enable = 1'b0; bus.up = 1'b0;
    endtask

    task automatic test_hold();
        #1;
        vecs++; if (bus.tc !== 1'b0) begin errs++; $display("FAIL hold_tc: got %b expected 0", bus.tc); end
        tick();
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL hold_q: got %0d expected 1", bus.q); end
    endtask

    task automatic test_cascade();
        sec_bus.load = 1'b1; sec_bus.load_val = 6'd59;
        hr_bus.load = 1'b1; hr_bus.load_val = 4'd12;
        tick();
        vecs++; if (sec_bus.q !== 6'd59) begin errs++; $display("FAIL cas_ld_sec: got %0d expected 59", sec_bus.q); end
        vecs++; if (hr_bus.q !== 4'd12) begin errs++; $display("FAIL cas_ld_hr: got %0d expected 12", hr_bus.q); end
        sec_bus.load = 1'b0; hr_bus.load = 1'b0;
        sec_bus.enable = 1'b1; sec_bus.up = 1'b1; hr_bus.up = 1'b1;
        #1;
        vecs++; if (sec_bus.tc !== 1'b1) begin errs++; $display("FAIL cas_sec_tc: got %b expected 1", sec_bus.tc); end
        vecs++; if (hr_bus.tc !== 1'b1) begin errs++; $display("FAIL cas_hr_tc: got %b expected 1", hr_bus.tc); end
        tick();
        vecs++; if (sec_bus.q !== 6'd0) begin errs++; $display("FAIL cas_sec_q: got %0d expected 0", sec_bus.q); end
        vecs++; if (hr_bus.q !== 4'd1) begin errs++; $display("FAIL cas_hr_q: got %0d expected 1", hr_bus.q); end
        vecs++; if (hr_bus.wrapped !== 1'b1) begin errs++; $display("FAIL cas_hr_wrapped: got %b expected 1", hr_bus.wrapped); end
        tick();
        vecs++; if (sec_bus.q !== 6'd1) begin errs++; $display("FAIL cas_sec_q2: got %0d expected 1", sec_bus.q); end
        vecs++; if (hr_bus.q !== 4'd1) begin errs++; $display("FAIL cas_hr_hold: got %0d expected 1", hr_bus.q); end
        sec_bus.enable = 1'b0;
    endtask

    task automatic test_pm();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0; bus.load = 1'b1; bus.load_val = 4'd10;
        tick();
        vecs++; if (bus.pm !== 1'b0) begin errs++; $display("FAIL pm_ld10: got %b expected 0", bus.pm); end
        bus.load = 1'b0; bus.enable = 1'b1; bus.up = 1'b1;
        tick();
        vecs++; if (bus.q !== 4'd11 || bus.pm !== 1'b0) begin errs++; $display("FAIL pm_11: got q=%0d pm=%b expected q=11 pm=0", bus.q, bus.pm); end
        tick();
        vecs++; if (bus.q !== 4'd12 || bus.pm !== PM_ON) begin errs++; $display("FAIL pm_12: got q=%0d pm=%b expected q=12 pm=%b", bus.q, bus.pm, PM_ON); end
        bus.enable = 1'b0; bus.load = 1'b1; bus.load_val = 4'd5;
        tick();
        vecs++; if (bus.q !== 4'd5 || bus.pm !== PM_ON) begin errs++; $display("FAIL pm_ld5: got q=%0d pm=%b expected q=5 pm=%b", bus.q, bus.pm, PM_ON); end
        bus.load_val = 4'd12;
        tick();
        bus.load = 1'b0; bus.enable = 1'b1; bus.up = 1'b0;
        tick();
        vecs++; if (bus.q !== 4'd11 || bus.pm !== 1'b0) begin errs++; $display("FAIL pm_dn11: got q=%0d pm=%b expected q=11 pm=0", bus.q, bus.pm); end
        bus.enable = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.enable = 1'b1; bus.up = 1'b1;
        tick();
        vecs++; if (bus.q !== 4'd12 || bus.pm !== PM_ON) begin errs++; $display("FAIL ar_pre: got q=%0d pm=%b expected q=12 pm=%b", bus.q, bus.pm, PM_ON); end
        #2 reset_n = 1'b0;
        #1;
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL ar_q: got %0d expected 1", bus.q); end
        vecs++; if (bus.pm !== 1'b0) begin errs++; $display("FAIL ar_pm: got %b expected 0", bus.pm); end
        bus.enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL ar_after_q: got %0d expected 1", bus.q); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_clr_priority();
        test_hold();
        test_cascade();
        test_pm();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_mod_range_counter
